// File: rtl/core_dmem_responder_if.sv
// Core data memory bus between the LSU (master) and a memory responder (slave).
// Handshake: master holds dmem_req with stable fields until the slave returns a one-cycle dmem_gnt carrying dmem_err/dmem_rdata.
interface core_dmem_responder_if;
    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_err;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        input  dmem_gnt, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        output dmem_gnt, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/core_dmem_responder.sv
// Data memory responder: serves dmem loads/stores from a byte-strobed 64-bit array after LATENCY cycles.
// Optional CORE_DMEM_RESP_STALL_EN adds 0..3 pseudo-random wait cycles per request from an 8-bit LFSR.
module core_dmem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic                        g_clk,
    input  logic                        g_reset,
    core_dmem_responder_if.slave        dmem,
    output logic [1:0]                  state_dbg
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] total_lat;
    logic [15:0] extra;
    logic [63:0] addr_q, wdata_q;
    logic        wen_q;
    logic [7:0]  strb_q;
    logic        gnt_q, gnt_d, err_q, err_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] cur_addr, cur_wdata, offset, lane_mask;
    logic        cur_wen, hit, go_resp, mem_we;
    logic [7:0]  cur_strb;
    logic [IDX_W-1:0] idx;
    logic [63:0] mem [DEPTH];
    logic        unused_bits;

`ifdef CORE_DMEM_RESP_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) lfsr_q <= 8'hA5;
        else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign extra = {14'd0, lfsr_q[1:0]};
`else
    assign extra = 16'd0;
`endif

    assign total_lat = 16'(LATENCY) + extra;

    // With a one-cycle latency the response is formed on the accept edge, so the live bus fields are used while IDLE.
    always_comb begin
        cur_addr  = addr_q;
        cur_wen   = wen_q;
        cur_strb  = strb_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_addr  = dmem.dmem_addr;
            cur_wen   = dmem.dmem_wen;
            cur_strb  = dmem.dmem_strb;
            cur_wdata = dmem.dmem_wdata;
        end
    end

    assign offset      = cur_addr - BASE_ADDR;
    assign idx         = offset[IDX_W+2:3];
    assign hit         = (cur_addr >= BASE_ADDR) && (cur_addr < LIMIT);
    assign unused_bits = ^{offset[63:IDX_W+3], offset[2:0]};

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) lane_mask[8*i +: 8] = {8{cur_strb[i]}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        gnt_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (dmem.dmem_req) begin
                    if (total_lat <= 16'd1) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = total_lat - 16'd2;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 16'd0) go_resp = 1'b1;
                else                cnt_d   = cnt_q - 16'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            state_d = RESP;
            gnt_d   = 1'b1;
            err_d   = !hit;
            if (hit && !cur_wen) rdata_d = mem[idx] & lane_mask;
        end
    end

    assign mem_we = go_resp && hit && cur_wen && !g_reset;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && dmem.dmem_req) begin
            addr_q  <= dmem.dmem_addr;
            wen_q   <= dmem.dmem_wen;
            strb_q  <= dmem.dmem_strb;
            wdata_q <= dmem.dmem_wdata;
        end
    end

    // Array contents are deliberately left unreset.
    always_ff @(posedge g_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++)
                if (cur_strb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
    end

    assign dmem.dmem_gnt   = gnt_q;
    assign dmem.dmem_err   = err_q;
    assign dmem.dmem_rdata = rdata_q;
    assign state_dbg       = state_q;
endmodule
